// File: rtl/adder_pkg.sv
// Shared types and defaults for the byte-serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: adder_state_t FSM encoding, default WIDTH/SLICE, slice_fits() legality check.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // True when WIDTH splits into a whole number of SLICE-bit pieces.
  // The top evaluates this at elaboration and stops the build if it fails.
  function automatic bit slice_fits(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/adder_slice_carry.sv
// One SLICE-bit unsigned add with carry in and carry out.
// Latency: combinational.
// Backpressure: none; pure datapath.
// Ports: a, b (SLICE) operands; cin carry in; s (SLICE) slice sum; cout carry out.
module adder_slice_carry
  import adder_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  // SLICE+1 bits wide so the carry out lands in the top bit.
  logic [SLICE:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign s        = full_sum[SLICE-1:0];
  assign cout     = full_sum[SLICE];

endmodule

// File: rtl/adder_serial_32bit.sv
// Byte-serial WIDTH-bit adder: one SLICE-bit slice per clock, carry kept in a register.
// Latency: WIDTH/SLICE cycles from accept edge to out_valid; one op per N+2 cycles best case.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no accept-on-drain.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b operands;
//        out_valid/out_ready with sum (mod 2^WIDTH) and cout (carry out of the MSB).
module adder_serial_32bit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (!slice_fits(WIDTH, SLICE)) begin : g_bad_slice
    $error("adder_serial_32bit: WIDTH must be a positive multiple of SLICE");
  end

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  // Slice k of the captured operands feeds the single adder stage.
  assign slice_a = a_q[idx_q*SLICE +: SLICE];
  assign slice_b = b_q[idx_q*SLICE +: SLICE];

  adder_slice_carry #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_serial_32bit.sv
// Self-checking bench for adder_serial_32bit: directed cases plus random back-to-back ops
// compared against a plain 33-bit addition reference.
module tb_adder_serial_32bit;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;

  int n_checks = 0;
  int n_errors = 0;

  adder_serial_32bit #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; drive and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, wait for result, optional stall, drain.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input int stall, input bit poke);
    logic [32:0] exp;
    int          cyc;
    exp = {1'b0, op_a} + {1'b0, op_b};
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    check("idle_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_in_ready", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = $urandom;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, N);
    check("sum", sum, exp[31:0]);
    check("cout", cout, exp[32]);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      step();
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, exp[31:0]);
      check("stall_cout", cout, exp[32]);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_in_ready", in_ready, 1);
    check("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] exp;
    int          t;
    int          last_acc;
    int          n_acc;
    int          n_res;
    bit          acc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    step();
    rst = 1'b0;
    step();

    // Basic add and full carry chain.
    run_op(32'h0000_0001, 32'h0000_0002, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);

    // Back-pressure: result held for 10 stalled cycles.
    run_op(32'h1234_5678, 32'h1111_1111, 10, 1'b0);

    // Input pulsed during RUN is ignored; next op still correct.
    run_op(32'hCAFE_0001, 32'h0F0F_F0F0, 0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);

    // Reset after slice 2 of an operation in flight.
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrun_in_ready", in_ready, 1);
    check("midrun_out_valid", out_valid, 0);
    check("midrun_sum", sum, 0);
    check("midrun_cout", cout, 0);
    step();
    rst = 1'b0;
    step();
    run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b0);

    // Back-to-back random ops with out_ready held high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    t = 0;
    last_acc = -1;
    n_acc = 0;
    n_res = 0;
    while (n_res < 100 && t < 2000) begin
      acc = in_ready && in_valid;
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b});
        if (last_acc >= 0) check("b2b_spacing", t - last_acc, N + 2);
        last_acc = t;
        n_acc++;
      end
      if (out_valid) begin
        if (q.size() > 0) begin
          exp = q.pop_front();
          check("b2b_sum", sum, exp[31:0]);
          check("b2b_cout", cout, exp[32]);
        end else begin
          check("b2b_unexpected_result", 1, 0);
        end
        n_res++;
      end
      step();
      t++;
      if (acc) begin
        a = $urandom;
        b = $urandom;
        if (n_acc >= 100) in_valid = 1'b0;
      end
    end
    check("b2b_results", n_res, 100);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
